// File: rtl/fxp_fma_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_fma_pipe
//  Purpose  : 3-stage handshaked fixed-point d = a*b + c, one rounding step
//             (half toward +inf) after the add, saturating to WIDTH bits.
//  Revision : 1.0
// ============================================================================
module fxp_fma_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             ovf
);

  localparam int c_PW = 2 * WIDTH;
  localparam int c_SW = 2 * WIDTH + 1;
  localparam logic [c_SW-1:0]  c_HALF = {{(c_SW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [WIDTH-1:0] c_DMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_DMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    r_v1;
  logic                    r_v2;
  logic                    r_v3;
  logic signed [WIDTH-1:0] r_a1;
  logic signed [WIDTH-1:0] r_b1;
  logic [WIDTH-1:0]        r_c1;
  logic [WIDTH-1:0]        r_c2;
  logic signed [c_PW-1:0]  r_p2;

  logic                    w_s1_load;
  logic                    w_s2_load;
  logic                    w_s3_load;
  logic signed [c_PW-1:0]  w_prod;
  logic [c_SW-1:0]         w_c_ext;
  logic signed [c_SW-1:0]  w_sum;
  logic signed [c_SW-1:0]  w_rnd;
  logic signed [c_SW-1:0]  w_r;
  logic [WIDTH+1:0]        w_hi;
  logic [WIDTH-1:0]        w_d;
  logic                    w_ovf;

  // Each stage advances when empty or when its successor advances, so bubbles collapse.
  assign w_s3_load = !r_v3 || out_ready;
  assign w_s2_load = !r_v2 || w_s3_load;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_v3;

  assign w_prod  = c_PW'(r_a1) * c_PW'(r_b1);
  assign w_c_ext = {{(c_SW-WIDTH){r_c2[WIDTH-1]}}, r_c2};
  assign w_sum   = $signed({r_p2[c_PW-1], r_p2}) + $signed(w_c_ext << FRAC_BITS);
  assign w_rnd   = w_sum + $signed(c_HALF);
  assign w_r     = w_rnd >>> FRAC_BITS;
  // In range exactly when every bit from WIDTH-1 upward is a copy of the sign.
  assign w_hi    = w_r[c_SW-1:WIDTH-1];

  always_comb begin
    w_d   = w_r[WIDTH-1:0];
    w_ovf = 1'b0;
    if (!(&w_hi) && (|w_hi)) begin
      w_ovf = 1'b1;
      w_d   = w_r[c_SW-1] ? c_DMIN : c_DMAX;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      d    <= '0;
      ovf  <= 1'b0;
    end else begin
      if (w_s1_load) r_v1 <= in_valid;
      if (w_s2_load) r_v2 <= r_v1;
      if (w_s3_load) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          d   <= w_d;
          ovf <= w_ovf;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_s1_load && in_valid) begin
      r_a1 <= a;
      r_b1 <= b;
      r_c1 <= c;
    end
    if (w_s2_load && r_v1) begin
      r_p2 <= w_prod;
      r_c2 <= r_c1;
    end
  end

endmodule
`default_nettype wire
